// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF1 fetch sequencer. Owns the fetch PC, issues aligned 1/2-wide groups,
// throttles on ICache miss / buffer full, redirects on branch flush, registers IF2 PCs.
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             buf_full,
  input  logic             br_flush,
  input  logic [31:0]      br_target,
  input  logic             icache_stall,
  input  logic             pred_taken,
  input  logic             pred_slot,
  input  logic [31:0]      pred_target,
  output logic             fetch_req,
  output logic [31:0]      fetch_pc,
  output logic [31:0]      if2_pc1,
  output logic [31:0]      if2_pc2,
  output logic [1:0]       if2_valid,
  output logic             if2_adef,
  output logic             flush_out,
  output logic [CNT_W-1:0] cnt_miss,
  output logic [CNT_W-1:0] cnt_full
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MISS       = 2'd1,
    ST_FLUSH_WAIT = 2'd2,
    ST_FULL       = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;

  logic        misaligned;
  logic        size2;
  logic        pred_hit;
  logic        accept;
  logic [31:0] seq_pc;
  logic [31:0] grp_next_pc;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign fetch_pc = pc;

  always_comb begin
    misaligned  = (pc[1:0] != 2'b00);
    size2       = !pc[2] && !(pred_taken && !pred_slot) && !misaligned;
    // A slot-1 prediction only matters when slot 1 is actually part of the group.
    pred_hit    = pred_taken && (!pred_slot || size2);
    seq_pc      = {pc[31:3] + 29'd1, 3'b000};
    grp_next_pc = pred_hit ? pred_target : seq_pc;
    accept      = ((state == ST_RUN) || (state == ST_MISS)) &&
                  !br_flush && !icache_stall && !buf_full;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      fetch_req <= 1'b1;
      if2_pc1   <= 32'd0;
      if2_pc2   <= 32'd0;
      if2_valid <= 2'b00;
      if2_adef  <= 1'b0;
      flush_out <= 1'b0;
      cnt_miss  <= '0;
      cnt_full  <= '0;
    end else begin
      flush_out <= br_flush;
      if2_valid <= 2'b00;
      if2_adef  <= 1'b0;

      if (accept) begin
        if2_pc1   <= pc;
        if2_pc2   <= pc + 32'd4;
        if2_valid <= size2 ? 2'b11 : 2'b10;
        if2_adef  <= misaligned;
        pc        <= grp_next_pc;
      end

      if ((state == ST_MISS) || (state == ST_FLUSH_WAIT))
        cnt_miss <= cnt_miss + CNT_ONE;
      if (state == ST_FULL)
        cnt_full <= cnt_full + CNT_ONE;

      case (state)
        ST_RUN: begin
          if (br_flush) begin
            pc <= br_target;
          end else if (icache_stall) begin
            state <= ST_MISS;
          end else if (buf_full) begin
            state     <= ST_FULL;
            fetch_req <= 1'b0;
          end
        end
        ST_MISS: begin
          if (br_flush) begin
            pc    <= br_target;
            // The refill for the old PC still completes; wait it out before fetching.
            state <= icache_stall ? ST_FLUSH_WAIT : ST_RUN;
          end else if (!icache_stall) begin
            if (buf_full) begin
              state     <= ST_FULL;
              fetch_req <= 1'b0;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_FLUSH_WAIT: begin
          if (br_flush) begin
            pc <= br_target;
          end else if (!icache_stall) begin
            state <= ST_RUN;
          end
        end
        ST_FULL: begin
          if (br_flush) begin
            pc        <= br_target;
            state     <= ST_RUN;
            fetch_req <= 1'b1;
          end else if (!buf_full) begin
            state     <= ST_RUN;
            fetch_req <= 1'b1;
          end
        end
        default: begin
          state     <= ST_RUN;
          fetch_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
